// File: rtl/pipeline_sequencer_pkg.sv
// Shared pipeline definitions: sequencer state encoding, bubble instruction,
// per-stage control bundle and the RUN-state priority helper.
package pipeline_defs;

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_HALTED   = 3'd3,
    ST_ERROR    = 3'd4
  } seq_state_e;

  // addi x0,x0,0 -- what a flushed IF/ID register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctrl_t;

  // Redirect beats halt beats load-use stall; halt and stall both freeze the
  // front end and inject a bubble into ID/EX while the back end keeps moving.
  function automatic pipe_ctrl_t run_ctrl(input logic br, input logic halt, input logic stall);
    pipe_ctrl_t c;
    c             = '1;
    c.if_id_flush = 1'b0;
    c.id_ex_flush = 1'b0;
    if (br) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (halt || stall) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_perf.sv
// Performance counters for the pipeline sequencer: total cycles, front-end
// stall cycles and applied redirects. All wrap modulo 2^CNT_W.
module pipeline_perf_counters
  import pipeline_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_cyc,
  input  logic             i_flush_cyc,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // count every clock out of reset, plus qualified stall/redirect cycles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (i_stall_cyc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (i_flush_cyc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline-register sequencer for the 5-stage core. Combines load-use stall,
// EX redirect, data-memory handshake and halt/resume into per-stage
// enable/flush controls. Optional perf counters: PIPELINE_SEQ_PERF_CNT_EN.
module pipeline_sequencer
  import pipeline_defs::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  seq_state_e r_state, w_next_state;
  logic [WCW-1:0] r_wait_cnt, w_wait_nxt;
  pipe_ctrl_t w_ctrl;

  // state and memory-wait counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_RST;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // next state and per-stage controls
  always_comb begin
    w_next_state = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_ctrl       = '0;
    case (r_state)
      ST_RST: begin
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
        w_wait_nxt         = '0;
        w_next_state       = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (r_state == ST_RUN && dmem_req_i && !dmem_ack_i) begin
          // whole pipe freezes; the request cycle counts as the first wait
          w_wait_nxt   = WCW'(1);
          w_next_state = ST_MEM_WAIT;
        end else if (r_state == ST_MEM_WAIT && !dmem_ack_i) begin
          if (r_wait_cnt == WCW'(MEM_TIMEOUT)) w_next_state = ST_ERROR;
          else                                 w_wait_nxt   = r_wait_cnt + WCW'(1);
        end else begin
          // normal flow, or the ack cycle releasing the held EX result
          w_ctrl       = run_ctrl(br_taken_i, halt_i, stall_i);
          w_wait_nxt   = '0;
          w_next_state = (halt_i && !br_taken_i) ? ST_HALTED : ST_RUN;
        end
      end
      ST_HALTED: begin
        w_ctrl.id_ex_en    = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
        w_ctrl.ex_mem_en   = 1'b1;
        w_ctrl.mem_wb_en   = 1'b1;
        if (resume_i) w_next_state = ST_RUN;
      end
      ST_ERROR: w_next_state = ST_ERROR;
      default:  w_next_state = ST_RST;
    endcase
  end

  assign pc_en_o       = w_ctrl.pc_en;
  assign if_id_en_o    = w_ctrl.if_id_en;
  assign if_id_flush_o = w_ctrl.if_id_flush;
  assign id_ex_en_o    = w_ctrl.id_ex_en;
  assign id_ex_flush_o = w_ctrl.id_ex_flush;
  assign ex_mem_en_o   = w_ctrl.ex_mem_en;
  assign mem_wb_en_o   = w_ctrl.mem_wb_en;
  assign halted_o      = (r_state == ST_HALTED);
  assign err_o         = (r_state == ST_ERROR);

`ifdef PIPELINE_SEQ_PERF_CNT_EN
  logic w_active, w_stall_cyc, w_flush_cyc;
  // only RUN/MEM_WAIT cycles are attributable to hazards or redirects
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
  assign w_stall_cyc = w_active && !w_ctrl.pc_en;
  assign w_flush_cyc = w_active && w_ctrl.if_id_flush;

  pipeline_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_stall_cyc (w_stall_cyc),
    .i_flush_cyc (w_flush_cyc),
    .o_cycle_cnt (cycle_cnt_o),
    .o_stall_cnt (stall_cnt_o),
    .o_flush_cnt (flush_cnt_o)
  );
`else
  assign cycle_cnt_o = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
